mix_columns_iter: RTL

//  Iterative AES MixColumns stage that consumes the 128-bit ShiftRows output and feeds AddRoundKey.
//  - Processes COLS_PER_CYCLE state columns per clock to trade area for latency.
//  - Valid/ready handshake on both sides.
//  - Final-round bypass: in_last=1 passes the state through unchanged.

---
 rtl/mix_columns_iter.sv | 64 ++++++
 1 files changed

// File: rtl/mix_columns_iter.sv
// mix_columns_iter: iterative AES MixColumns stage with final-round bypass and valid/ready handshake
module mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);
  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [31:0] mix(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction
  state_t       state, state_n;
  logic [1:0]   col;
  logic [127:0] src;
  logic [1:0]   idx   [COLS_PER_CYCLE];
  logic [31:0]  mixed [COLS_PER_CYCLE];
  // column c occupies bits [32*(3-c) +: 32], i.e. base {~c, 5'b0}
  for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_lane
    assign idx[j]   = col + 2'(j);
    assign mixed[j] = mix(src[{~idx[j], 5'b0} +: 32]);
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n   = state;
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    if (state == IDLE && in_valid) state_n = in_last ? DONE : BUSY;
    else if (state == BUSY && idx[COLS_PER_CYCLE-1] == 2'd3) state_n = DONE;
    else if (state == DONE && out_ready) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      src      <= '0;
      col      <= '0;
      out_data <= '0;
    end else if (state == IDLE && in_valid) begin
      src <= in_data;
      col <= '0;
      if (in_last) out_data <= in_data;
    end else if (state == BUSY) begin
      for (int k = 0; k < COLS_PER_CYCLE; k++) out_data[{~idx[k], 5'b0} +: 32] <= mixed[k];
      col <= col + STEP;
    end
  end
endmodule
